// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: field-width defaults, bubble opcode fill and
// the skid-stage occupancy encoding.
package pipe_stage_skid_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned OP_W_DEF   = 6;
  localparam int unsigned RD_W_DEF   = 5;
  localparam int unsigned WB_W_DEF   = 2;

  // Default bubble opcode is this bit replicated across the op field (all-ones).
  localparam bit NOOP_OP_FILL = 1'b1;

  // Occupancy of the stage: nothing held, MAIN held, MAIN and SKID held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one registered pipeline entry (all fields plus a valid bit).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            capture d_* and mark the slot valid
//   clr             empty the slot to bubble values (wins over load)
//   d_*             entry fields to capture
//   valid, q_*      registered slot contents; bubble values when empty
module pipe_slot
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter int unsigned       OP_W    = OP_W_DEF,
  parameter int unsigned       RD_W    = RD_W_DEF,
  parameter int unsigned       WB_W    = WB_W_DEF,
  parameter logic [OP_W-1:0]   NOOP_OP = {OP_W{NOOP_OP_FILL}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_alu,
  input  logic [DATA_W-1:0] d_mem,
  input  logic [OP_W-1:0]   d_op,
  input  logic [RD_W-1:0]   d_rd,
  input  logic [RD_W-1:0]   d_res,
  input  logic [WB_W-1:0]   d_wb,
  output logic              valid,
  output logic [DATA_W-1:0] q_alu,
  output logic [DATA_W-1:0] q_mem,
  output logic [OP_W-1:0]   q_op,
  output logic [RD_W-1:0]   q_rd,
  output logic [RD_W-1:0]   q_res,
  output logic [WB_W-1:0]   q_wb
);

  // An empty slot always holds bubble values so its outputs can drive the
  // stage outputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q_alu <= '0;
      q_mem <= '0;
      q_op  <= NOOP_OP;
      q_rd  <= '0;
      q_res <= '0;
      q_wb  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      q_alu <= '0;
      q_mem <= '0;
      q_op  <= NOOP_OP;
      q_rd  <= '0;
      q_res <= '0;
      q_wb  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q_alu <= d_alu;
      q_mem <= d_mem;
      q_op  <= d_op;
      q_rd  <= d_rd;
      q_res <= d_res;
      q_wb  <= d_wb;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid-buffered pipeline register. MAIN drives the
// outputs; SKID catches the one entry accepted while MAIN is stalled, so
// in_ready depends only on registered state and never on out_ready.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous discard of all held entries
//   in_valid, in_ready       upstream handshake
//   in_alu..in_wb            incoming entry fields
//   out_valid, out_ready     downstream handshake
//   out_alu..out_wb          registered entry fields (bubble when not valid)
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter int unsigned       OP_W    = OP_W_DEF,
  parameter int unsigned       RD_W    = RD_W_DEF,
  parameter int unsigned       WB_W    = WB_W_DEF,
  parameter logic [OP_W-1:0]   NOOP_OP = {OP_W{NOOP_OP_FILL}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [OP_W-1:0]   in_op,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [RD_W-1:0]   in_res,
  input  logic [WB_W-1:0]   in_wb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [OP_W-1:0]   out_op,
  output logic [RD_W-1:0]   out_rd,
  output logic [RD_W-1:0]   out_res,
  output logic [WB_W-1:0]   out_wb
);

  skid_state_e state_q, state_d;

  logic main_load, main_clr, main_from_skid;
  logic skid_load, skid_clr;
  logic skid_valid;
  logic accept, emit;

  logic [DATA_W-1:0] skid_alu, skid_mem;
  logic [OP_W-1:0]   skid_op;
  logic [RD_W-1:0]   skid_rd, skid_res;
  logic [WB_W-1:0]   skid_wb;

  logic [DATA_W-1:0] main_d_alu, main_d_mem;
  logic [OP_W-1:0]   main_d_op;
  logic [RD_W-1:0]   main_d_rd, main_d_res;
  logic [WB_W-1:0]   main_d_wb;

  // Ready is a flop output (inverted): open exactly while SKID is free.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;

  // Occupancy transitions and slot load/clear controls.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (emit) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_TWO: begin
          // SKID is full so no accept can occur here.
          if (emit) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // MAIN refills from SKID when draining, otherwise straight from the inputs.
  always_comb begin
    main_d_alu = in_alu;
    main_d_mem = in_mem;
    main_d_op  = in_op;
    main_d_rd  = in_rd;
    main_d_res = in_res;
    main_d_wb  = in_wb;
    if (main_from_skid) begin
      main_d_alu = skid_alu;
      main_d_mem = skid_mem;
      main_d_op  = skid_op;
      main_d_rd  = skid_rd;
      main_d_res = skid_res;
      main_d_wb  = skid_wb;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W),
    .RD_W   (RD_W),
    .WB_W   (WB_W),
    .NOOP_OP(NOOP_OP)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .clr  (main_clr),
    .d_alu(main_d_alu),
    .d_mem(main_d_mem),
    .d_op (main_d_op),
    .d_rd (main_d_rd),
    .d_res(main_d_res),
    .d_wb (main_d_wb),
    .valid(out_valid),
    .q_alu(out_alu),
    .q_mem(out_mem),
    .q_op (out_op),
    .q_rd (out_rd),
    .q_res(out_res),
    .q_wb (out_wb)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W),
    .RD_W   (RD_W),
    .WB_W   (WB_W),
    .NOOP_OP(NOOP_OP)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .clr  (skid_clr),
    .d_alu(in_alu),
    .d_mem(in_mem),
    .d_op (in_op),
    .d_rd (in_rd),
    .d_res(in_res),
    .d_wb (in_wb),
    .valid(skid_valid),
    .q_alu(skid_alu),
    .q_mem(skid_mem),
    .q_op (skid_op),
    .q_rd (skid_rd),
    .q_res(skid_res),
    .q_wb (skid_wb)
  );

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32: width of each of the two payload fields (alu result, mem out).
REQ-002 Parameter OP_W, default 6: operation field width.
REQ-003 Parameter RD_W, default 5: destination/result register index width.
REQ-004 Parameter WB_W, default 2: write-back control width.
REQ-005 Parameter NOOP_OP, default all-ones of OP_W: operation code driven for a bubble.
REQ-006 clk  in  1  clock, all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush  in  1  synchronous discard of all held entries.
REQ-009 in_valid  in  1  upstream entry present.
REQ-010 in_ready  out  1  stage can accept this cycle.
REQ-011 in_alu, in_mem  in  DATA_W each  payload fields.
REQ-012 in_op  in  OP_W; in_rd, in_res  in  RD_W each; in_wb  in  WB_W.
REQ-013 out_valid  out  1  output entry present.
REQ-014 out_ready  in  1  downstream accepts this cycle.
REQ-015 out_alu, out_mem, out_op, out_rd, out_res, out_wb  out  widths as inputs  registered entry fields.

Function
REQ-016 Accept occurs when in_valid and in_ready are both high at a rising edge; emit occurs when out_valid and out_ready are both high.
REQ-017 Two entry slots: MAIN (drives outputs) and SKID; states EMPTY, ONE (MAIN full), TWO (MAIN and SKID full).
REQ-018 in_ready shall be high exactly when SKID is empty, derived only from registered state, with no combinational path from out_ready.
REQ-019 EMPTY + accept -> ONE, with MAIN loaded; latency input-to-output is one cycle.
REQ-020 ONE + accept + emit -> ONE, with MAIN reloaded from the inputs.
REQ-021 ONE + accept, no emit -> TWO, with the inputs captured in SKID.
REQ-022 ONE + emit, no accept -> EMPTY.
REQ-023 TWO + emit -> ONE, with SKID moved into MAIN; accept is impossible in TWO.
REQ-024 Entries shall leave in arrival order; no entry is dropped or duplicated except by flush or rst.
REQ-025 When out_valid is low, the stage shall drive a bubble: out_op=NOOP_OP, out_wb=0, out_rd=0, out_res=0, out_alu=0, out_mem=0.
REQ-026 flush shall force EMPTY at the next edge, overriding any same-cycle accept or emit; an entry offered during the flush cycle is discarded.
REQ-027 Outputs shall be stable while out_valid is high and out_ready is low.

Reset
REQ-028 rst shall immediately force EMPTY, with both slots cleared and outputs at bubble values (out_op=NOOP_OP, all others 0), out_valid=0 and in_ready=1.
REQ-029 rst asserted mid-transfer shall discard all held entries; the first accept after release behaves as from EMPTY.

Structure
REQ-030 A shared pipeline package shall hold the NOOP_OP default, the field-width defaults and the three-value state encoding.
REQ-031 A single flop-slot sub-module, pipe_slot, shall hold one entry (all fields plus a valid bit) and be instantiated twice (MAIN and SKID).

Verification
REQ-032 Streaming, out_ready=1: inputs op=0x23, alu=0x10 presented on cycles 1-4 -> the same values appear on out_* on cycles 2-5, in_ready remains 1.
REQ-033 Backpressure: out_ready=0 while 2 entries (A, B) are accepted -> in_ready=0 after B; with out_ready=1, A then B emerge on consecutive cycles and in_ready returns to 1.
REQ-034 Flush in TWO with in_valid=1 in the same cycle -> next cycle out_valid=0, out_op=0x3F, in_ready=1; neither held entry nor the offered entry ever appears.
REQ-035 Asynchronous rst pulsed between clock edges while in ONE -> out_valid=0 and out_op=0x3F before the next edge.
REQ-036 Parameter sweep DATA_W=64, OP_W=8, NOOP_OP=0x00 -> bubble out_op=0x00; a 64-bit payload of 0xDEADBEEF_CAFEF00D passes through intact.
REQ-037 Random valid/ready stimulus over 10k cycles against a scoreboard -> output sequence equals the accepted sequence, with no in_ready/out_ready combinational loop.
